// File: rtl/key_conditioner.sv
// Push-button conditioner: two-flop synchroniser, polarity normalisation, per-key
// debounce, and one-cycle press / release / long-hold strobes for the game logic.
module key_conditioner #(
    parameter int KEYS_W          = 4,
    parameter bit KEYS_ACTIVE_LOW = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEYS_W-1:0] keys_raw_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] press_o,
    output logic [KEYS_W-1:0] release_o,
    output logic [KEYS_W-1:0] hold_o
);

    localparam int                DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [KEYS_W-1:0] IDLE_RAW = {KEYS_W{KEYS_ACTIVE_LOW}};

    logic [KEYS_W-1:0] sync1;
    logic [KEYS_W-1:0] sync2;
    logic [KEYS_W-1:0] norm;
    logic [DB_W-1:0]   db_cnt [KEYS_W];

    // Reset the synchroniser to the idle pin level so no phantom press follows reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= keys_raw_i;
            sync2 <= sync1;
        end
    end

    assign norm = sync2 ^ IDLE_RAW;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            keys_o    <= '0;
            press_o   <= '0;
            release_o <= '0;
            for (int i = 0; i < KEYS_W; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            press_o   <= '0;
            release_o <= '0;
            for (int i = 0; i < KEYS_W; i++) begin
                if (norm[i] == keys_o[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    keys_o[i]    <= norm[i];
                    press_o[i]   <= norm[i];
                    release_o[i] <= ~norm[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int              HC_W    = $clog2(HOLD_CYCLES + 1);
            localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

            logic [HC_W-1:0]   hold_cnt [KEYS_W];
            logic [KEYS_W-1:0] fired;

            // The counter freezes once fired so a single press yields one hold pulse.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    hold_o <= '0;
                    fired  <= '0;
                    for (int i = 0; i < KEYS_W; i++) begin
                        hold_cnt[i] <= '0;
                    end
                end else begin
                    hold_o <= '0;
                    for (int i = 0; i < KEYS_W; i++) begin
                        if (!keys_o[i]) begin
                            hold_cnt[i] <= '0;
                            fired[i]    <= 1'b0;
                        end else if (!fired[i]) begin
                            if (hold_cnt[i] == HC_LAST) begin
                                hold_o[i] <= 1'b1;
                                fired[i]  <= 1'b1;
                            end else begin
                                hold_cnt[i] <= hold_cnt[i] + HC_W'(1);
                            end
                        end
                    end
                end
            end
        end else begin : g_no_hold
            assign hold_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity, all
// checked against a window/timestamp reference model of the conditioning rules.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys_raw = 4'hF;
    logic [3:0] keys_o, press_o, release_o, hold_o;

    int checks = 0;
    int failures = 0;

    key_conditioner #(
        .KEYS_W(4), .KEYS_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)
    ) dut (
        .clk_i(clk), .rst_i(rst), .keys_raw_i(keys_raw),
        .keys_o(keys_o), .press_o(press_o), .release_o(release_o), .hold_o(hold_o)
    );

    always #5 clk = ~clk;

    // Reference model: the synced pressed level reaches the debouncer two edges after
    // sampling; a key flips once its last D synced samples all disagree with it;
    // hold fires H edges after the rise while the key has stayed down.
    logic [3:0]   m_p1 = '0, m_p2 = '0, m_n = '0, m_old = '0, m_st = '0;
    logic [D-1:0] m_win [4];
    int           m_fill [4];
    int           m_rise [4];
    bit           m_risev [4];
    int           edge_n = 0;
    logic [3:0]   exp_keys = '0, exp_press = '0, exp_rel = '0, exp_hold = '0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_p1 = '0; m_p2 = '0; m_st = '0;
            exp_keys = '0; exp_press = '0; exp_rel = '0; exp_hold = '0;
            for (int i = 0; i < 4; i++) begin
                m_win[i] = '0; m_fill[i] = 0; m_risev[i] = 1'b0;
            end
        end else begin
            m_n  = m_p2;
            m_p2 = m_p1;
            m_p1 = ~keys_raw;
            m_old = m_st;
            for (int i = 0; i < 4; i++) begin
                m_win[i] = {m_win[i][D-2:0], m_n[i]};
                if (m_fill[i] < D) m_fill[i]++;
                if (m_fill[i] == D && m_win[i] == {D{~m_old[i]}}) m_st[i] = ~m_old[i];
            end
            exp_press = m_st & ~m_old;
            exp_rel   = ~m_st & m_old;
            for (int i = 0; i < 4; i++) begin
                exp_hold[i] = m_old[i] && m_risev[i] && (edge_n - m_rise[i] == H);
                if (exp_press[i]) begin
                    m_rise[i]  = edge_n;
                    m_risev[i] = 1'b1;
                end
            end
            exp_keys = m_st;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        keys_raw = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if ({keys_o, press_o, release_o, hold_o} !== 16'h0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got %h required 0000", k,
                         {keys_o, press_o, release_o, hold_o});
            end
        end
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        keys_raw[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (keys_o[0] !== logic'(k >= 5) || press_o[0] !== logic'(k == 5)) begin
                failures++;
                $display("FAIL clean_press_timing edge %0d: keys0=%b press0=%b required %b %b",
                         k, keys_o[0], press_o[0], k >= 5, k == 5);
            end
            checks++;
            if ({keys_o[3:1], press_o[3:1], release_o, hold_o} !== 14'h0) begin
                failures++;
                $display("FAIL clean_press_quiet edge %0d: got %h required 0", k,
                         {keys_o[3:1], press_o[3:1], release_o, hold_o});
            end
        end
        keys_raw[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({keys_o, press_o, release_o, hold_o} !== {exp_keys, exp_press, exp_rel, exp_hold}) begin
                failures++;
                $display("FAIL clean_release_model edge %0d: got %h required %h", k,
                         {keys_o, press_o, release_o, hold_o}, {exp_keys, exp_press, exp_rel, exp_hold});
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat = 7'b0001000;
        int presses = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (keys_o[1] !== logic'(k - 1 >= 9)) begin
                    failures++;
                    $display("FAIL bounce_level edge %0d: keys1=%b required %b", k - 1, keys_o[1], k - 1 >= 9);
                end
                checks++;
                if ({keys_o, press_o, release_o, hold_o} !== {exp_keys, exp_press, exp_rel, exp_hold}) begin
                    failures++;
                    $display("FAIL bounce_model edge %0d: got %h required %h", k - 1,
                             {keys_o, press_o, release_o, hold_o}, {exp_keys, exp_press, exp_rel, exp_hold});
                end
                if (press_o[1]) presses++;
            end
            keys_raw[1] = (k < 7) ? pat[6 - k] : 1'b0;
        end
        checks++;
        if (presses != 1) begin
            failures++;
            $display("FAIL bounce_press_count: got %0d required 1", presses);
        end
        keys_raw[1] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_hold();
        int rise_k = -1, hold_k = -1, holds = 0, presses = 0;
        keys_raw[2] = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (press_o[2]) begin presses++; rise_k = k; end
            if (hold_o[2]) begin holds++; hold_k = k; end
            checks++;
            if ({keys_o, press_o, release_o, hold_o} !== {exp_keys, exp_press, exp_rel, exp_hold}) begin
                failures++;
                $display("FAIL hold_model edge %0d: got %h required %h", k,
                         {keys_o, press_o, release_o, hold_o}, {exp_keys, exp_press, exp_rel, exp_hold});
            end
        end
        checks++;
        if (presses != 1 || holds != 1 || rise_k != 5 || hold_k != 15) begin
            failures++;
            $display("FAIL hold_timing: presses=%0d holds=%0d rise=%0d hold=%0d required 1 1 5 15",
                     presses, holds, rise_k, hold_k);
        end
        keys_raw[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (release_o[2] !== logic'(k == 5) || hold_o[2] !== 1'b0) begin
                failures++;
                $display("FAIL hold_release edge %0d: release2=%b hold2=%b required %b 0",
                         k, release_o[2], hold_o[2], k == 5);
            end
        end
    endtask

    task automatic test_glitch();
        keys_raw[3] = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (k == 2) keys_raw[3] = 1'b1;
            checks++;
            if ({keys_o[3], press_o[3], release_o[3]} !== 3'b000) begin
                failures++;
                $display("FAIL glitch_reject edge %0d: got %b required 000", k,
                         {keys_o[3], press_o[3], release_o[3]});
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int waited = 0;
        keys_raw[0] = 1'b0;
        while (keys_o[0] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (keys_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold_press_timeout: keys0=%b required 1", keys_o[0]);
        end
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({keys_o, press_o, release_o, hold_o} !== 16'h0) begin
            failures++;
            $display("FAIL reset_hold_clear: got %h required 0000", {keys_o, press_o, release_o, hold_o});
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (keys_o[0] !== logic'(k >= 5) || press_o[0] !== logic'(k == 5) || hold_o[0] !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold_redebounce edge %0d: keys0=%b press0=%b hold0=%b required %b %b 0",
                         k, keys_o[0], press_o[0], hold_o[0], k >= 5, k == 5);
            end
        end
        keys_raw[0] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if ({keys_o, press_o, release_o, hold_o} !== {exp_keys, exp_press, exp_rel, exp_hold}) begin
                failures++;
                $display("FAIL random_model cycle %0d: got %h required %h", k,
                         {keys_o, press_o, release_o, hold_o}, {exp_keys, exp_press, exp_rel, exp_hold});
            end
            checks++;
            if ((press_o & release_o) !== 4'h0) begin
                failures++;
                $display("FAIL random_press_release_overlap cycle %0d: got %h required 0", k, press_o & release_o);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) keys_raw[i] = ~keys_raw[i];
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_glitch();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Input conditioning stage directly upstream of the game logic. It sits between the raw board push-buttons and the game logic's key inputs. For each key it:
- synchronises the raw input into clk_i,
- normalises polarity,
- debounces with a per-key counter,
- produces a clean level plus one-cycle press, release and long-hold strobes.

Its keys_o output drives the game logic key inputs: key0 = down, key1 = up, key2 = game restart.

Parameters:
KEYS_W, 4, number of keys; equals board_pkg::KEYS_W at top level.
KEYS_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (inverted after sync); 0 = active-high.
DEBOUNCE_CYCLES, 500000, consecutive stable synced cycles needed to accept a new level (10 ms at 50 MHz); legal range is 1 or more.
HOLD_CYCLES, 50000000, cycles a debounced key must stay pressed before hold_o fires (1 s at 50 MHz); 0 disables hold detection.

Ports:
clk_i       input   1       board clock
rst_i       input   1       synchronous reset, active-high
keys_raw_i  input   KEYS_W  raw asynchronous button pins
keys_o      output  KEYS_W  debounced level, 1 = pressed
press_o     output  KEYS_W  one-cycle pulse on debounced 0->1
release_o   output  KEYS_W  one-cycle pulse on debounced 1->0
hold_o      output  KEYS_W  one-cycle pulse after HOLD_CYCLES continuous press

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. Every flop is registered on posedge clk_i.
- Reset values:
  - sync stages = "not pressed" after polarity normalisation (raw-level 1 when KEYS_ACTIVE_LOW = 1);
  - debounce and hold counters = 0;
  - keys_o, press_o, release_o, hold_o = 0.
- Synchroniser: two-flop chain per key (s1, s2). Polarity is applied on s2's output: n = s2 XOR KEYS_ACTIVE_LOW.
- Debounce, per key, with state: stable level st and counter cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - if n == st: cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: st <= n, cnt <= 0;
  - else: cnt <= cnt+1.
- Latency: a raw level first sampled at edge 0 and held steady appears on keys_o after edge DEBOUNCE_CYCLES+1.
- Glitches: any bounce back to st before acceptance clears cnt. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches keys_o.
- Edge strobes:
  - press_o[i] = 1 for exactly the cycle after keys_o[i] rises (registered on the same edge st updates);
  - release_o[i] behaves the same on a fall;
  - press_o and release_o are never high together for the same key.
- Hold detection, per key, with counter hc and a fired flag:
  - while keys_o[i] == 1 and fired is clear: hc increments each cycle;
  - when hc == HOLD_CYCLES-1: hold_o[i] pulses for one cycle, fired is set, hc stops;
  - on release: hc and fired clear;
  - at most one hold_o pulse per press;
  - HOLD_CYCLES == 0: hold_o tied 0 and hold logic removed.
- Keys are fully independent. Simultaneous transitions on several keys produce simultaneous strobes.
- Reset asserted mid-debounce or mid-hold: all state returns to reset values on that edge. A key still held after reset is re-debounced: it takes DEBOUNCE_CYCLES+1 edges after reset deassertion and then raises press_o again.
- Counters never wrap: the debounce counter saturates by construction, and hc freezes once fired.

Test Plan:
All scenarios use KEYS_W=4, KEYS_ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
1. Reset, keys_raw_i=4'b1111 held -> keys_o=0, all strobes 0 for 20 cycles.
2. Clean press: keys_raw_i[0] 1->0 first sampled at edge 0 and held -> keys_o[0]=1 after edge 5; press_o[0]=1 for exactly one cycle; other keys quiet.
3. Bounce: keys_raw_i[1] toggles 0,0,0,1,0,0,0 per cycle -> keys_o[1] stays 0 until 4 consecutive synced 0s, then rises; a single press_o[1] pulse.
4. Hold: key2 pressed and held 30 cycles -> press_o[2] pulse, then hold_o[2] one-cycle pulse 10 cycles after keys_o[2] rose, no second pulse. On release: release_o[2] one-cycle pulse 5 edges after raw goes high.
5. Glitch rejection: 3-cycle low pulse on key3 -> keys_o[3], press_o[3], release_o[3] all stay 0.
6. Reset mid-hold: key0 held 7 cycles after press, rst_i for 1 cycle -> outputs 0 on that edge; with the key still held, keys_o[0] rises again 5 edges after reset deasserts, with a new press_o[0] pulse.
